arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 87 ++++++++
 tb/tb_arb_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-to-1 valid/ready arbiter-mux with fixed or round-robin
// grant feeding a single registered output slot.
module arb_mux #(
   parameter  int NUM_IN = 4,
   parameter  int WIDTH  = 1,
   localparam int SELW   = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SELW-1:0]         sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SELW-1:0]         out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic              load;
   logic              gnt_ok;
   logic [SELW-1:0]   gnt;
   logic [SELW-1:0]   ptr;
   logic [SELW-1:0]   idx;
   logic [WIDTH-1:0]  gnt_data;
   int                pos;

   assign load = !out_valid || out_ready;

   // Round-robin scan runs from farthest to nearest so the
   // nearest valid channel after ptr is the last one written.
   always_comb begin
      gnt_ok = 1'b0;
      gnt    = '0;
      idx    = '0;
      pos    = 0;
      if (!mode) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SELW'(i) && in_valid[SELW'(i)]) begin
               gnt_ok = 1'b1;
               gnt    = SELW'(i);
            end
         end
      end else begin
         for (int k = NUM_IN; k >= 1; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_IN)
               pos = pos - NUM_IN;
            idx = SELW'(pos);
            if (in_valid[idx]) begin
               gnt_ok = 1'b1;
               gnt    = idx;
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gnt == SELW'(i))
            gnt_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign in_ready = (gnt_ok && load && !rst)
                   ? (NUM_IN'(1) << gnt)
                   : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SELW'(NUM_IN - 1);
      end else if (load) begin
         out_valid <= gnt_ok;
         if (gnt_ok) begin
            out_data <= gnt_data;
            out_ch   <= gnt;
            ptr      <= gnt;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: random and directed checks of arb_mux against a
// cycle-level reference model of the grant and output-slot rules.
module tb_arb_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [1:0]     sel;
   logic [W-1:0]   out_data;
   logic [1:0]     out_ch;
   logic           out_valid;
   logic           out_ready;

   logic           d3_rst;
   logic [3*W-1:0] d3_in_data;
   logic [2:0]     d3_in_valid;
   logic [2:0]     d3_in_ready;
   logic           d3_mode;
   logic [1:0]     d3_sel;
   logic [W-1:0]   d3_out_data;
   logic [1:0]     d3_out_ch;
   logic           d3_out_valid;
   logic           d3_out_ready;

   int total = 0;
   int bad   = 0;

   int m_ptr = N - 1;
   bit m_v   = 1'b0;
   int m_d   = 0;
   int m_c   = 0;

   always #5 clk = ~clk;

   arb_mux #(.NUM_IN(N), .WIDTH(W)) u_dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel),
      .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   arb_mux #(.NUM_IN(3), .WIDTH(W)) u_dut3 (
      .clk(clk), .rst(d3_rst),
      .in_data(d3_in_data), .in_valid(d3_in_valid),
      .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel),
      .out_data(d3_out_data), .out_ch(d3_out_ch),
      .out_valid(d3_out_valid), .out_ready(d3_out_ready)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Spec-level grant: fixed index or first valid after ptr.
   function automatic int grant();
      int i;
      if (!mode)
         return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
      for (int k = 1; k <= N; k++) begin
         i = (m_ptr + k) % N;
         if (in_valid[i])
            return i;
      end
      return -1;
   endfunction

   task automatic cycle();
      int         g;
      bit         ld;
      logic [N-1:0] er;
      #1;
      g  = grant();
      ld = !m_v || out_ready;
      er = '0;
      if (!rst && ld && g >= 0)
         er[g] = 1'b1;
      chk("in_ready", in_ready, er);
      if (rst) begin
         m_v = 0; m_d = 0; m_c = 0; m_ptr = N - 1;
      end else if (ld) begin
         if (g >= 0) begin
            m_v = 1; m_d = int'(in_data[g*W +: W]);
            m_c = g; m_ptr = g;
         end else begin
            m_v = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, m_v);
      chk("out_data", out_data, m_d);
      chk("out_ch", out_ch, m_c);
   endtask

   task automatic drive(input bit r, input bit md,
                        input logic [1:0] s,
                        input logic [3:0] v, input bit ordy);
      @(negedge clk);
      rst = r; mode = md; sel = s;
      in_valid = v; out_ready = ordy;
      in_data = $urandom;
   endtask

   logic [W-1:0] hd;
   logic [1:0]   hc;

   initial begin
      rst = 1; mode = 0; sel = 0; in_valid = 0;
      out_ready = 0; in_data = 0;
      d3_rst = 1; d3_mode = 0; d3_sel = 0;
      d3_in_valid = 0; d3_in_data = 0; d3_out_ready = 0;

      drive(1, 0, 0, 4'hF, 1); cycle();
      drive(1, 1, 0, 4'hF, 1); cycle();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ch", out_ch, 0);

      // fixed select of channel 2
      drive(0, 0, 2, 4'hF, 1);
      in_data[23:16] = 8'hA5;
      #1 chk("fix_rdy", in_ready, 4'b0100);
      cycle();
      chk("fix_data", out_data, 8'hA5);
      chk("fix_ch", out_ch, 2);

      // round-robin from reset: 0,1,2,3,0
      drive(1, 1, 0, 4'hF, 1); cycle();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 0, 4'hF, 1); cycle();
         chk("rr_seq", out_ch, k % 4);
      end

      // sparse valids 1010 from ptr=3
      drive(1, 1, 0, 4'hF, 1); cycle();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 0, 4'b1010, 1); cycle();
         chk("rr_sparse", out_ch, (k % 2) ? 3 : 1);
      end

      // backpressure hold then resume
      drive(0, 1, 0, 4'hF, 1); cycle();
      hd = out_data; hc = out_ch;
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 4'hF, 0);
         #1 chk("stall_rdy", in_ready, 0);
         cycle();
         chk("stall_data", out_data, hd);
         chk("stall_ch", out_ch, hc);
      end
      drive(0, 1, 0, 4'hF, 1); cycle();
      chk("resume_ch", out_ch, (hc + 1) % 4);
      chk("resume_v", out_valid, 1);

      // mid-stream reset
      drive(1, 1, 0, 4'hF, 0); cycle();
      chk("mrst_valid", out_valid, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_ch", out_ch, 0);
      drive(0, 1, 0, 4'hF, 1); cycle();
      chk("mrst_first", out_ch, 0);

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 63) == 0,
               1'($urandom), 2'($urandom), 4'($urandom),
               $urandom_range(0, 3) != 0);
         cycle();
      end

      // NUM_IN=3: out-of-range select never grants
      @(negedge clk);
      rst = 0; in_valid = 0;
      d3_rst = 1; d3_in_valid = 3'b111;
      d3_in_data = 24'h332211;
      @(negedge clk);
      d3_rst = 0; d3_sel = 1; d3_out_ready = 0;
      #1 chk("n3_rdy1", d3_in_ready, 3'b010);
      @(posedge clk); #1;
      chk("n3_v1", d3_out_valid, 1);
      chk("n3_d1", d3_out_data, 8'h22);
      @(negedge clk);
      d3_sel = 3;
      #1 chk("n3_rdy_hold", d3_in_ready, 0);
      @(posedge clk); #1;
      chk("n3_v_hold", d3_out_valid, 1);
      @(negedge clk);
      d3_out_ready = 1;
      #1 chk("n3_rdy_oor", d3_in_ready, 0);
      @(posedge clk); #1;
      chk("n3_v_drain", d3_out_valid, 0);
      chk("n3_ch_keep", d3_out_ch, 1);
      chk("n3_d_keep", d3_out_data, 8'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
